fib_stream_checker: RTL and testbench
=====================================

Name: fib_stream_checker

Overview:
- Sits directly downstream of the team's Fibonacci sequence generator and consumes its DATA_WIDTH output word stream.
- Locks onto the stream after two seed terms, then checks every further term equals the sum of the previous two (mod 2^DATA_WIDTH).
- Reports lock status, per-term mismatch pulses, and saturating match and mismatch counters.
- Used as a self-checking monitor in generator bring-up and as an on-chip sequence integrity checker.

Parameters:
- DATA_WIDTH, 32, width of the checked term; all arithmetic is mod 2^DATA_WIDTH.
- COUNT_WIDTH, 16, width of the match and mismatch counters.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  din carries a term this cycle.
- din  input  DATA_WIDTH  term from the upstream generator.
- locked  output  1  checker holds two valid history terms (state TRACK).
- expected  output  DATA_WIDTH  next term expected (prev+cur); 0 unless locked.
- err  output  1  one-cycle pulse: the last accepted term mismatched.
- match_count  output  COUNT_WIDTH  terms checked and matched, saturating.
- mismatch_count  output  COUNT_WIDTH  terms checked and mismatched, saturating.

Behaviour:
- Reset (async assert, sync-safe release): state EMPTY, history regs prev=cur=0, locked=0, expected=0, err=0, both counters 0. Asserting reset mid-stream discards all history immediately.
- All outputs are registered. Effect of a term sampled at edge N is visible after edge N. err is high exactly one cycle.
- in_valid low: no state, history or counter change; err deasserts.
- FSM:
  - EMPTY: on valid, cur<=din, go to ONE.
  - ONE: on valid, prev<=cur, cur<=din, go to TRACK, locked<=1.
  - TRACK: on valid, compare din with prev+cur (truncated to DATA_WIDTH, carry discarded).
    - Match: prev<=cur, cur<=din, match_count++.
    - Mismatch: err<=1, mismatch_count++, cur<=din, go to ONE, locked<=0. The bad term becomes the new first seed, so the checker resyncs after one more term.
- expected = prev+cur while in TRACK, 0 otherwise. It updates in the same cycle as the history regs.
- Seed terms (EMPTY and ONE) are never compared and never counted.
- Counters saturate at 2^COUNT_WIDTH-1 and do not wrap.
- Wrap-around: a wrapped sum is a valid expected value. The checker must stay locked through an upstream modular wrap.

Optional Feature:
- Macro: FIB_CHK_WRAP_FLAG_EN.
- Defined: adds output wrap_seen (1 bit, reset 0). Sticky-sets after any matched TRACK term whose sum prev+cur produced a carry out of DATA_WIDTH. Cleared only by reset.
- Undefined: port and carry logic absent; all other behaviour identical.

Test Plan:
- Reset, then feed 1,1,2,3,5,8 with in_valid every cycle -> locked=1 after 2nd term; after 6th term match_count=4, mismatch_count=0, expected=13, err never high.
- Continue the above with 7 instead of 13 -> err high exactly one cycle, mismatch_count=1, locked=0. Then feed 20 -> prev=7, cur=20, locked=1, expected=27.
- Feed 1,1,2 with in_valid low for 3 cycles between terms, then 3 -> match_count=2, no err, state unaffected by idle cycles.
- DATA_WIDTH=8: feed 89,144,233 (mod 256 =233), then 121 (377 mod 256) -> match_count=2, no err, locked stays 1. With FIB_CHK_WRAP_FLAG_EN defined, wrap_seen=1 after the 121 term.
- COUNT_WIDTH=3: feed a correct stream of 12 terms -> match_count saturates at 7, does not wrap to 0.
- Assert resetn low asynchronously, between edges, mid-stream after 5 matched terms -> outputs return to 0 and locked=0 immediately, without a clock edge. After release, feeding 1,1,2 gives match_count=1.

Source files
------------

// File: rtl/fib_stream_checker.sv
// Fibonacci stream integrity checker: locks after two seed terms, then flags any term != prev+cur.
// Optional FIB_CHK_WRAP_FLAG_EN adds a sticky wrap_seen flag for matched terms whose sum carried out.
module fib_stream_checker #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   locked,
    output logic [DATA_WIDTH-1:0]  expected,
    output logic                   err,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic [COUNT_WIDTH-1:0] mismatch_count
`ifdef FIB_CHK_WRAP_FLAG_EN
    ,
    output logic                   wrap_seen
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TRACK
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  prev_q, prev_d;
    logic [DATA_WIDTH-1:0]  cur_q, cur_d;
    logic [DATA_WIDTH-1:0]  exp_q, exp_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] match_q, match_d;
    logic [COUNT_WIDTH-1:0] mismatch_q, mismatch_d;
    logic [DATA_WIDTH-1:0]  sum;

`ifdef FIB_CHK_WRAP_FLAG_EN
    logic [DATA_WIDTH:0]    sum_full;
    logic                   wrap_q, wrap_d;

    assign sum_full = {1'b0, prev_q} + {1'b0, cur_q};
    assign sum      = sum_full[DATA_WIDTH-1:0];
`else
    // Modular sum: the carry is dropped, so an upstream wrap still matches.
    assign sum = prev_q + cur_q;
`endif

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches);
    // combinational logic uses blocking '=', the register process below uses non-blocking '<='.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;
        err_d      = 1'b0;
`ifdef FIB_CHK_WRAP_FLAG_EN
        wrap_d     = wrap_q;
`endif
        if (in_valid) begin
            case (state_q)
                S_EMPTY: begin
                    cur_d   = din;
                    state_d = S_ONE;
                end
                S_ONE: begin
                    prev_d  = cur_q;
                    cur_d   = din;
                    state_d = S_TRACK;
                end
                S_TRACK: begin
                    if (din == sum) begin
                        prev_d = cur_q;
                        cur_d  = din;
                        if (match_q != COUNT_MAX) match_d = match_q + COUNT_ONE;
`ifdef FIB_CHK_WRAP_FLAG_EN
                        if (sum_full[DATA_WIDTH]) wrap_d = 1'b1;
`endif
                    end else begin
                        // The bad term becomes the new first seed; relock after one more term.
                        err_d   = 1'b1;
                        cur_d   = din;
                        state_d = S_ONE;
                        if (mismatch_q != COUNT_MAX) mismatch_d = mismatch_q + COUNT_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        locked_d = (state_d == S_TRACK);
        exp_d    = locked_d ? (prev_d + cur_d) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_EMPTY;
            prev_q     <= '0;
            cur_q      <= '0;
            exp_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            match_q    <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            exp_q      <= exp_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
        end
    end

`ifdef FIB_CHK_WRAP_FLAG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wrap_q <= 1'b0;
        else         wrap_q <= wrap_d;
    end

    assign wrap_seen = wrap_q;
`endif

    assign locked         = locked_q;
    assign expected       = exp_q;
    assign err            = err_q;
    assign match_count    = match_q;
    assign mismatch_count = mismatch_q;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Scoreboard bench for fib_stream_checker: a 32/16 instance and an 8/3 instance driven from one clock.
// Expected outputs come from a behavioural model pushed to queues and popped after each edge.
module tb_fib_stream_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_a, valid_b;
    logic [31:0] din_a;
    logic [7:0]  din_b;

    logic        locked_a, err_a;
    logic [31:0] expected_a;
    logic [15:0] match_a, mismatch_a;
    logic        locked_b, err_b;
    logic [7:0]  expected_b;
    logic [2:0]  match_b, mismatch_b;
`ifdef FIB_CHK_WRAP_FLAG_EN
    logic        wrap_a, wrap_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_stream_checker #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .resetn(resetn), .in_valid(valid_a), .din(din_a),
        .locked(locked_a), .expected(expected_a), .err(err_a),
        .match_count(match_a), .mismatch_count(mismatch_a)
`ifdef FIB_CHK_WRAP_FLAG_EN
        , .wrap_seen(wrap_a)
`endif
    );

    fib_stream_checker #(.DATA_WIDTH(8), .COUNT_WIDTH(3)) dut_b (
        .clk(clk), .resetn(resetn), .in_valid(valid_b), .din(din_b),
        .locked(locked_b), .expected(expected_b), .err(err_b),
        .match_count(match_b), .mismatch_count(mismatch_b)
`ifdef FIB_CHK_WRAP_FLAG_EN
        , .wrap_seen(wrap_b)
`endif
    );

    typedef struct {
        int          st;   // 0 empty, 1 one seed, 2 tracking
        logic [31:0] prev;
        logic [31:0] cur;
        int          mc;
        int          mmc;
        bit          err;
        bit          wrap;
    } model_t;

    typedef struct packed {
        logic        locked;
        logic [31:0] expv;
        logic        err;
        logic [31:0] mc;
        logic [31:0] mmc;
        logic        wrap;
    } exp_t;

    model_t      mdl [2];
    logic [31:0] mask [2] = '{32'hffff_ffff, 32'h0000_00ff};
    int          cmax [2] = '{65535, 7};
    exp_t        q_a [$];
    exp_t        q_b [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        mdl[k].st   = 0;
        mdl[k].prev = '0;
        mdl[k].cur  = '0;
        mdl[k].mc   = 0;
        mdl[k].mmc  = 0;
        mdl[k].err  = 1'b0;
        mdl[k].wrap = 1'b0;
    endtask

    task automatic model_step(input int k, input bit v, input logic [31:0] d);
        logic [32:0] s;
        bit          carry;
        mdl[k].err = 1'b0;
        if (v) begin
            s     = {1'b0, mdl[k].prev} + {1'b0, mdl[k].cur};
            carry = (k == 0) ? s[32] : s[8];
            if (mdl[k].st == 0) begin
                mdl[k].cur = d;
                mdl[k].st  = 1;
            end else if (mdl[k].st == 1) begin
                mdl[k].prev = mdl[k].cur;
                mdl[k].cur  = d;
                mdl[k].st   = 2;
            end else if ((s[31:0] & mask[k]) == d) begin
                mdl[k].prev = mdl[k].cur;
                mdl[k].cur  = d;
                if (mdl[k].mc < cmax[k]) mdl[k].mc++;
                if (carry) mdl[k].wrap = 1'b1;
            end else begin
                mdl[k].err = 1'b1;
                mdl[k].cur = d;
                mdl[k].st  = 1;
                if (mdl[k].mmc < cmax[k]) mdl[k].mmc++;
            end
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.locked = (mdl[k].st == 2);
        e.expv   = e.locked ? ((mdl[k].prev + mdl[k].cur) & mask[k]) : 32'd0;
        e.err    = mdl[k].err;
        e.mc     = 32'(mdl[k].mc);
        e.mmc    = 32'(mdl[k].mmc);
        e.wrap   = mdl[k].wrap;
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        e = q_a.pop_front();
        check("a_locked",   32'(locked_a),   32'(e.locked));
        check("a_expected", expected_a,      e.expv);
        check("a_err",      32'(err_a),      32'(e.err));
        check("a_match",    32'(match_a),    e.mc);
        check("a_mismatch", 32'(mismatch_a), e.mmc);
`ifdef FIB_CHK_WRAP_FLAG_EN
        check("a_wrap",     32'(wrap_a),     32'(e.wrap));
`endif
        e = q_b.pop_front();
        check("b_locked",   32'(locked_b),   32'(e.locked));
        check("b_expected", 32'(expected_b), e.expv);
        check("b_err",      32'(err_b),      32'(e.err));
        check("b_match",    32'(match_b),    e.mc);
        check("b_mismatch", 32'(mismatch_b), e.mmc);
`ifdef FIB_CHK_WRAP_FLAG_EN
        check("b_wrap",     32'(wrap_b),     32'(e.wrap));
`endif
    endtask

    // Drive one cycle: instance k gets (v, d), the other instance idles.
    task automatic step(input int k, input bit v, input logic [31:0] d);
        valid_a = (k == 0) && v;
        din_a   = d;
        valid_b = (k == 1) && v;
        din_b   = d[7:0];
        model_step(0, (k == 0) && v, d);
        model_step(1, (k == 1) && v, d & 32'hff);
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        compare_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_locked"},   32'(locked_a),   32'd0);
        check({tag, "_a_expected"}, expected_a,      32'd0);
        check({tag, "_a_err"},      32'(err_a),      32'd0);
        check({tag, "_a_match"},    32'(match_a),    32'd0);
        check({tag, "_a_mismatch"}, 32'(mismatch_a), 32'd0);
        check({tag, "_b_locked"},   32'(locked_b),   32'd0);
        check({tag, "_b_expected"}, 32'(expected_b), 32'd0);
        check({tag, "_b_match"},    32'(match_b),    32'd0);
`ifdef FIB_CHK_WRAP_FLAG_EN
        check({tag, "_b_wrap"},     32'(wrap_b),     32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seq_a [6] = '{1, 1, 2, 3, 5, 8};
        logic [31:0] seq_b [4] = '{89, 144, 233, 121};
        logic [31:0] fa, fb, fn;

        resetn  = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        din_a   = '0;
        din_b   = '0;
        model_reset(0);
        model_reset(1);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Basic lock and match on the 32-bit instance.
        for (int i = 0; i < 6; i++) begin
            step(0, 1'b1, seq_a[i]);
            if (i == 1) check("a_locked_after_seed2", 32'(locked_a), 32'd1);
        end
        check("a_expected_13", expected_a, 32'd13);
        check("a_match_4", 32'(match_a), 32'd4);

        // Mismatch, one-cycle err, resync on the bad term.
        step(0, 1'b1, 32'd7);
        check("a_err_pulse", 32'(err_a), 32'd1);
        check("a_mismatch_1", 32'(mismatch_a), 32'd1);
        step(0, 1'b0, 32'd0);
        check("a_err_cleared", 32'(err_a), 32'd0);
        step(0, 1'b1, 32'd20);
        check("a_relock_expected_27", expected_a, 32'd27);

        // 8-bit wrap, then saturation of the 3-bit match counter.
        for (int i = 0; i < 4; i++) step(1, 1'b1, seq_b[i]);
        check("b_match_2", 32'(match_b), 32'd2);
        check("b_locked_through_wrap", 32'(locked_b), 32'd1);
`ifdef FIB_CHK_WRAP_FLAG_EN
        check("b_wrap_set", 32'(wrap_b), 32'd1);
`endif
        fa = 32'd233;
        fb = 32'd121;
        for (int i = 0; i < 8; i++) begin
            fn = (fa + fb) & 32'hff;
            step(1, 1'b1, fn);
            fa = fb;
            fb = fn;
        end
        check("b_match_saturated_7", 32'(match_b), 32'd7);

        // Asynchronous reset mid-stream after five matched terms.
        @(negedge clk);
        resetn = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        resetn = 1'b1;
        step(0, 1'b1, 32'd1);
        step(0, 1'b1, 32'd1);
        for (int i = 0; i < 5; i++) step(0, 1'b1, mdl[0].prev + mdl[0].cur);
        check("a_match_5", 32'(match_a), 32'd5);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        resetn = 1'b1;

        // Idle cycles between terms leave the state untouched.
        step(0, 1'b1, 32'd1);
        for (int j = 0; j < 3; j++) step(0, 1'b0, 32'd99);
        step(0, 1'b1, 32'd1);
        for (int j = 0; j < 3; j++) step(0, 1'b0, 32'd99);
        step(0, 1'b1, 32'd2);
        check("a_match_1_after_reset", 32'(match_a), 32'd1);
        for (int j = 0; j < 3; j++) step(0, 1'b0, 32'd99);
        step(0, 1'b1, 32'd3);
        check("a_match_2_with_idles", 32'(match_a), 32'd2);
        check("a_no_err_with_idles", 32'(mismatch_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
